// File: rtl/uart_dmi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_dmi_bridge: byte-framed UART command front end for a RISC-V DMI.    |
// | Optional frame checksum: define UART_DMI_BRIDGE_CHECKSUM_EN.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module uart_dmi_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK_I,
  input  logic        RST_NI,
  input  logic        RX_EMPTY_I,
  output logic        RE_O,
  input  logic [7:0]  DREC_I,
  input  logic        TX_READY_I,
  output logic        WE_O,
  output logic [7:0]  DSEND_O,
  output logic        DMI_REQ_VALID_O,
  input  logic        DMI_REQ_READY_I,
  output logic [6:0]  DMI_REQ_ADDR_O,
  output logic [31:0] DMI_REQ_DATA_O,
  output logic [1:0]  DMI_REQ_OP_O,
  input  logic        DMI_RESP_VALID_I,
  output logic        DMI_RESP_READY_O,
  input  logic [31:0] DMI_RESP_DATA_I,
  input  logic [1:0]  DMI_RESP_OP_I
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_REQ  = 3'd4,
    S_WAIT = 3'd5,
    S_SEND = 3'd6
  } state_t;

  localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Index of the final response byte; the checksum, when present, sits last.
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
  localparam state_t     PAYLOAD_DONE = S_CHK;
  localparam logic [2:0] RD_LAST      = 3'd5;
  localparam logic [2:0] WR_LAST      = 3'd1;
`else
  localparam state_t     PAYLOAD_DONE = S_REQ;
  localparam logic [2:0] RD_LAST      = 3'd4;
  localparam logic [2:0] WR_LAST      = 3'd0;
`endif

  state_t            state_q, state_d;
  logic [1:0]        rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              req_valid_q, req_valid_d;
  logic [6:0]        req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic [1:0]        req_op_q, req_op_d;
  logic [7:0]        status_q, status_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic [2:0]        tx_last_q, tx_last_d;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
  logic [7:0]        rx_sum_q, rx_sum_d;
  logic              tx_sum_en_q, tx_sum_en_d;
`endif

  logic              w_rx_state;
  logic              w_pop;
  logic [7:0]        w_tx_byte;

  always_comb begin
    w_rx_state = 1'b0;
    case (state_q)
      S_IDLE, S_ADDR, S_DATA: w_rx_state = 1'b1;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
      S_CHK:                  w_rx_state = 1'b1;
`endif
      default:                w_rx_state = 1'b0;
    endcase
  end

  assign w_pop = RST_NI && w_rx_state && !RX_EMPTY_I;

  always_comb begin
    state_d     = state_q;
    rx_cnt_d    = rx_cnt_q;
    to_cnt_d    = to_cnt_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    tx_idx_d    = tx_idx_q;
    tx_last_d   = tx_last_q;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
    rx_sum_d    = rx_sum_q;
    tx_sum_en_d = tx_sum_en_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          if (DREC_I == 8'h01 || DREC_I == 8'h02) begin
            // Command code doubles as the DMI op encoding.
            req_op_d   = DREC_I[1:0];
            req_data_d = 32'h0;
            state_d    = S_ADDR;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
            rx_sum_d   = DREC_I;
`endif
          end else begin
            status_d  = 8'hFF;
            rdata_d   = 32'h0;
            tx_idx_d  = 3'd0;
            tx_last_d = 3'd0;
            state_d   = S_SEND;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
            tx_sum_en_d = 1'b0;
`endif
          end
        end
      end
      S_ADDR: begin
        if (w_pop) begin
          req_addr_d = DREC_I[6:0];
          rx_cnt_d   = 2'd0;
          state_d    = req_op_q[1] ? S_DATA : PAYLOAD_DONE;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
          rx_sum_d   = rx_sum_q ^ DREC_I;
`endif
        end
      end
      S_DATA: begin
        if (w_pop) begin
          req_data_d[8*rx_cnt_q +: 8] = DREC_I;
          rx_cnt_d = rx_cnt_q + 2'd1;
          if (rx_cnt_q == 2'd3) state_d = PAYLOAD_DONE;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
          rx_sum_d = rx_sum_q ^ DREC_I;
`endif
        end
      end
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
      S_CHK: begin
        if (w_pop) begin
          if (DREC_I == rx_sum_q) begin
            state_d = S_REQ;
          end else begin
            status_d    = 8'hFE;
            rdata_d     = 32'h0;
            tx_idx_d    = 3'd0;
            tx_last_d   = 3'd0;
            tx_sum_en_d = 1'b0;
            state_d     = S_SEND;
          end
        end
      end
`endif
      S_REQ: begin
        if (!req_valid_q) begin
          req_valid_d = 1'b1;
        end else if (DMI_REQ_READY_I) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DMI_RESP_VALID_I) begin
          status_d  = {6'b0, DMI_RESP_OP_I};
          rdata_d   = req_op_q[1] ? 32'h0 : DMI_RESP_DATA_I;
          tx_last_d = req_op_q[1] ? WR_LAST : RD_LAST;
          tx_idx_d  = 3'd0;
          state_d   = S_SEND;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
          tx_sum_en_d = 1'b1;
`endif
        end
      end
      S_SEND: begin
        if (TX_READY_I) begin
          if (tx_idx_q == tx_last_q) begin
            tx_idx_d = 3'd0;
            state_d  = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout only runs while a frame is partially received.
    if (w_rx_state && state_q != S_IDLE) begin
      if (w_pop) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d = '0;
        state_d  = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_comb begin
    w_tx_byte = status_q;
    case (tx_idx_q)
      3'd1:    w_tx_byte = rdata_q[7:0];
      3'd2:    w_tx_byte = rdata_q[15:8];
      3'd3:    w_tx_byte = rdata_q[23:16];
      3'd4:    w_tx_byte = rdata_q[31:24];
      default: w_tx_byte = status_q;
    endcase
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
    // rdata_q is zero for writes, so the same XOR covers both response kinds.
    if (tx_sum_en_q && tx_idx_q == tx_last_q)
      w_tx_byte = status_q ^ rdata_q[7:0] ^ rdata_q[15:8] ^ rdata_q[23:16] ^ rdata_q[31:24];
`endif
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      state_q     <= S_IDLE;
      rx_cnt_q    <= 2'd0;
      to_cnt_q    <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 7'h0;
      req_data_q  <= 32'h0;
      req_op_q    <= 2'd0;
      status_q    <= 8'h0;
      rdata_q     <= 32'h0;
      tx_idx_q    <= 3'd0;
      tx_last_q   <= 3'd0;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
      rx_sum_q    <= 8'h0;
      tx_sum_en_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_cnt_q    <= rx_cnt_d;
      to_cnt_q    <= to_cnt_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      tx_idx_q    <= tx_idx_d;
      tx_last_q   <= tx_last_d;
`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
      rx_sum_q    <= rx_sum_d;
      tx_sum_en_q <= tx_sum_en_d;
`endif
    end
  end

  assign RE_O             = w_pop;
  assign WE_O             = RST_NI && state_q == S_SEND && TX_READY_I;
  assign DSEND_O          = (RST_NI && state_q == S_SEND) ? w_tx_byte : 8'h00;
  assign DMI_REQ_VALID_O  = req_valid_q;
  assign DMI_REQ_ADDR_O   = req_addr_q;
  assign DMI_REQ_DATA_O   = req_data_q;
  assign DMI_REQ_OP_O     = req_op_q;
  assign DMI_RESP_READY_O = RST_NI && state_q == S_WAIT;

endmodule

`default_nettype wire

// File: tb/tb_uart_dmi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_dmi_bridge: directed bench with UART FIFO and DMI target models. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_uart_dmi_bridge;

`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_empty = 1'b1;
  logic        re;
  logic [7:0]  drec = 8'h00;
  logic        tx_ready = 1'b1;
  logic        we;
  logic [7:0]  dsend;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_data = 32'h0;
  logic [1:0]  resp_op = 2'd0;

  always #5 clk = ~clk;

  uart_dmi_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .CLK_I            (clk),
    .RST_NI           (rst_n),
    .RX_EMPTY_I       (rx_empty),
    .RE_O             (re),
    .DREC_I           (drec),
    .TX_READY_I       (tx_ready),
    .WE_O             (we),
    .DSEND_O          (dsend),
    .DMI_REQ_VALID_O  (req_valid),
    .DMI_REQ_READY_I  (req_ready),
    .DMI_REQ_ADDR_O   (req_addr),
    .DMI_REQ_DATA_O   (req_data),
    .DMI_REQ_OP_O     (req_op),
    .DMI_RESP_VALID_I (resp_valid),
    .DMI_RESP_READY_O (resp_ready),
    .DMI_RESP_DATA_I  (resp_data),
    .DMI_RESP_OP_I    (resp_op)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic [6:0]  rq_addr[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_op[$];
  int          req_delay = 0;
  bit          resp_hold = 1'b0;
  bit          tx_toggle = 1'b0;
  int          wait_cnt  = 0;
  int          low_cnt   = 0;
  int          unstable  = 0;
  int          proto_err = 0;
  logic [31:0] cfg_data  = 32'h0;
  logic [1:0]  cfg_op    = 2'd0;

  // Sample at negedge what the coming posedge will do, apply it just after.
  initial begin : drv
    bit          s_pop, s_push, s_req, s_resp;
    logic [7:0]  s_byte;
    logic [6:0]  s_a, snap_a;
    logic [31:0] s_d, snap_d;
    logic [1:0]  s_o, snap_o;
    snap_a = '0; snap_d = '0; snap_o = '0;
    forever begin
      @(negedge clk);
      s_pop  = re;
      s_push = we;
      s_byte = dsend;
      s_req  = req_valid && req_ready;
      s_resp = resp_valid && resp_ready;
      s_a = req_addr; s_d = req_data; s_o = req_op;
      if ((re && rx_empty) || (we && !tx_ready)) proto_err++;
      if (req_valid) begin
        if (wait_cnt == 0) begin
          snap_a = req_addr; snap_d = req_data; snap_o = req_op;
        end else if ({req_addr, req_data, req_op} !== {snap_a, snap_d, snap_o}) begin
          unstable++;
        end
        if (!req_ready) low_cnt++;
        wait_cnt++;
      end
      @(posedge clk);
      #1;
      if (s_pop) void'(rx_q.pop_front());
      if (s_push) tx_log.push_back(s_byte);
      if (s_req) begin
        rq_addr.push_back(s_a);
        rq_data.push_back(s_d);
        rq_op.push_back(s_o);
        wait_cnt = 0;
        if (!resp_hold) begin
          resp_valid = 1'b1;
          resp_data  = cfg_data;
          resp_op    = cfg_op;
        end
      end
      if (s_resp) resp_valid = 1'b0;
      req_ready = (wait_cnt >= req_delay);
      tx_ready  = tx_toggle ? ~tx_ready : 1'b1;
      rx_empty  = (rx_q.size() == 0);
      drec      = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input byte_q_t b);
    foreach (b[i]) rx_q.push_back(b[i]);
  endtask

  task automatic push_chk(input logic [7:0] c);
    if (CHK) rx_q.push_back(c);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    rq_addr.delete();
    rq_data.delete();
    rq_op.delete();
  endtask

  task automatic expect_tx(input string tag, input byte_q_t exp, input logic [7:0] chk, input bit add_chk);
    int budget;
    if (CHK && add_chk) exp.push_back(chk);
    budget = 400;
    while (tx_log.size() < exp.size() && budget > 0) begin
      cycles(1);
      budget--;
    end
    cycles(8);
    check_eq({tag, " tx count"}, 32'(tx_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check_eq($sformatf("%s tx[%0d]", tag, i),
               (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD0000, 32'(exp[i]));
  endtask

  task automatic check_req(input string tag, input int n, input logic [6:0] a,
                           input logic [31:0] d, input logic [1:0] o);
    check_eq({tag, " req count"}, 32'(rq_addr.size()), 32'(n));
    if (rq_addr.size() > 0) begin
      check_eq({tag, " req addr"}, 32'(rq_addr[$]), 32'(a));
      check_eq({tag, " req data"}, rq_data[$], d);
      check_eq({tag, " req op"}, 32'(rq_op[$]), 32'(o));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, " RE_O"}, 32'(re), 32'h0);
    check_eq({tag, " WE_O"}, 32'(we), 32'h0);
    check_eq({tag, " DSEND_O"}, 32'(dsend), 32'h0);
    check_eq({tag, " REQ_VALID"}, 32'(req_valid), 32'h0);
    check_eq({tag, " REQ_ADDR"}, 32'(req_addr), 32'h0);
    check_eq({tag, " REQ_DATA"}, req_data, 32'h0);
    check_eq({tag, " REQ_OP"}, 32'(req_op), 32'h0);
    check_eq({tag, " RESP_READY"}, 32'(resp_ready), 32'h0);
  endtask

  initial begin : main
    int budget;
    rst_n = 1'b0;
    cycles(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    cycles(2);

    // Read 0x10 -> status 00 then DEADBEEF LSB first
    clear_logs();
    cfg_data = 32'hDEADBEEF; cfg_op = 2'd0;
    push('{8'h01, 8'h10}); push_chk(8'h11);
    expect_tx("rd", '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 8'h22, 1'b1);
    check_req("rd", 1, 7'h10, 32'h0, 2'd1);

    // Write with request ready held low for 5 valid cycles
    clear_logs();
    req_delay = 5; low_cnt = 0; unstable = 0;
    cfg_data = 32'hFFFFFFFF; cfg_op = 2'd0;
    push('{8'h02, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12}); push_chk(8'h0E);
    expect_tx("wr", '{8'h00}, 8'h00, 1'b1);
    check_req("wr", 1, 7'h04, 32'h12345678, 2'd2);
    check_eq("wr ready-low cycles", 32'(low_cnt), 32'd5);
    check_eq("wr fields stable", 32'(unstable), 32'd0);
    req_delay = 0;

    // Bad command, then a read queued behind it
    clear_logs();
    cfg_data = 32'hCAFEF00D; cfg_op = 2'd0;
    push('{8'h55, 8'h01, 8'h10}); push_chk(8'h11);
    expect_tx("bad", '{8'hFF, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA}, 8'hC9, 1'b1);
    check_req("bad", 1, 7'h10, 32'h0, 2'd1);

    // Partial write abandoned by timeout, then a read
    clear_logs();
    push('{8'h02, 8'h04});
    cycles(30);
    check_eq("timeout tx count", 32'(tx_log.size()), 32'd0);
    check_eq("timeout req count", 32'(rq_addr.size()), 32'd0);
    cfg_data = 32'h000000FF; cfg_op = 2'd3;
    push('{8'h01, 8'h00}); push_chk(8'h01);
    expect_tx("to-rd", '{8'h03, 8'hFF, 8'h00, 8'h00, 8'h00}, 8'hFC, 1'b1);
    check_req("to-rd", 1, 7'h00, 32'h0, 2'd1);

    // Gaps below the timeout must not accumulate across pops
    clear_logs();
    cfg_op = 2'd2;
    push('{8'h02}); cycles(12);
    push('{8'h04, 8'h78}); cycles(12);
    push('{8'h56, 8'h34, 8'h12}); push_chk(8'h0E);
    expect_tx("gap", '{8'h02}, 8'h02, 1'b1);
    check_req("gap", 1, 7'h04, 32'h12345678, 2'd2);

    // TX backpressure toggling, address bit 7 ignored
    clear_logs();
    cfg_data = 32'h01234567; cfg_op = 2'd0;
    tx_toggle = 1'b1;
    push('{8'h01, 8'h85}); push_chk(8'h84);
    expect_tx("bp", '{8'h00, 8'h67, 8'h45, 8'h23, 8'h01}, 8'h00, 1'b1);
    tx_toggle = 1'b0;
    check_req("bp", 1, 7'h05, 32'h0, 2'd1);

    // Reset while waiting for the DMI response
    clear_logs();
    resp_hold = 1'b1;
    push('{8'h01, 8'h10}); push_chk(8'h11);
    budget = 50;
    while (!resp_ready && budget > 0) begin
      cycles(1);
      budget--;
    end
    check_eq("reached WAIT", 32'(resp_ready), 32'h1);
    rst_n = 1'b0;
    cycles(1);
    check_outputs_zero("rst-wait");
    rst_n = 1'b1;
    resp_hold = 1'b0;
    cycles(20);
    check_eq("rst-wait tx count", 32'(tx_log.size()), 32'd0);
    check_eq("rst-wait req count", 32'(rq_addr.size()), 32'd1);

`ifdef UART_DMI_BRIDGE_CHECKSUM_EN
    // Wrong checksum -> 0xFE, no DMI request
    clear_logs();
    push('{8'h01, 8'h10, 8'h00});
    expect_tx("badsum", '{8'hFE}, 8'h00, 1'b0);
    check_eq("badsum req count", 32'(rq_addr.size()), 32'd0);
`endif

    check_eq("protocol violations", 32'(proto_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
